// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory request/response port between an instruction-fetch
// requester (read only) and a load/store requester. Exactly one transaction is
// in flight at a time. The FSM walks IDLE -> REQ -> RSP -> IDLE:
//   IDLE : arbitrate, pulse the winner's grant, latch its request fields
//   REQ  : present the latched request to memory until mem_gnt_i
//   RSP  : wait for mem_rvalid_i and route the response to the owner
// The data side has priority. When the macro MEM_ARB_STARVE_GUARD_EN is
// defined, a 2-bit counter lets fetch win one contested arbitration after
// three consecutive contested data wins.
//
// Parameters
//   ADDR_W        address width
//   DATA_W        data width (byte enables are DATA_W/8 wide)
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   if_req_i, if_addr_i           fetch request (held until if_gnt_o)
//   if_gnt_o                      fetch accepted (one-cycle pulse)
//   if_rvalid_o, if_rdata_o       fetch response
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i, d_be_i             load/store request (held until d_gnt_o)
//   d_gnt_o                       load/store accepted (one-cycle pulse)
//   d_rvalid_o, d_rdata_o         load/store response
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o,
//   mem_be_o                      shared memory request (zero when idle)
//   mem_gnt_i                     memory accepted the request
//   mem_rvalid_i, mem_rdata_i     memory response (reads and writes)
//   busy_o                        high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // instruction fetch side
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  // load/store side
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_W-1:0]     d_rdata_o,
  // shared memory port
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  // status
  output logic                  busy_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q,    be_d;
  logic                we_q,    we_d;

  logic                win_d;      // data side wins this cycle
  logic                win_i;      // fetch side wins this cycle
  logic                contested;  // both sides requesting in IDLE
  logic                rsp_take;   // response accepted this cycle

  assign contested = d_req_i && if_req_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [1:0]          starve_q, starve_d;
`endif

  // -------------------------------------------------------------------------
  // Arbitration. Grants are only issued from IDLE and are gated with rst_ni
  // so that nothing is granted while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    win_d = 1'b0;
    win_i = 1'b0;
    if (rst_ni && (state_q == ST_IDLE)) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      // After three consecutive contested data wins the fetch side gets
      // one turn so it cannot be starved by a stream of loads/stores.
      if (contested && (starve_q == 2'd3)) begin
        win_i = 1'b1;
      end else if (d_req_i) begin
        win_d = 1'b1;
      end else if (if_req_i) begin
        win_i = 1'b1;
      end
`else
      if (d_req_i) begin
        win_d = 1'b1;
      end else if (if_req_i) begin
        win_i = 1'b1;
      end
`endif
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts consecutive contested arbitrations won by the data side; any
  // uncontested arbitration, or a contested one won by fetch, clears it.
  always_comb begin
    starve_d = starve_q;
    if (win_d || win_i) begin
      if (contested && win_d) begin
        starve_d = starve_q + 2'd1;
      end else begin
        starve_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next state and request latching
  // -------------------------------------------------------------------------
  assign rsp_take = (state_q == ST_RSP) && mem_rvalid_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_d) begin
          owner_d = OWN_D;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          be_d    = d_be_i;
          we_d    = d_we_i;
          state_d = ST_REQ;
        end else if (win_i) begin
          owner_d = OWN_I;
          addr_d  = if_addr_i;
          wdata_d = '0;
          be_d    = '1;
          we_d    = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A response arriving together with the grant is not taken here;
        // it can only be accepted from the RSP state onwards.
        if (mem_gnt_i) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (mem_rvalid_i) begin
          owner_d = OWN_NONE;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The memory request fields are forced to zero outside REQ so the
  // bus never shows stale values while no request is presented.
  // -------------------------------------------------------------------------
  always_comb begin
    if_gnt_o    = win_i;
    d_gnt_o     = win_d;

    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (state_q == ST_REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_be_o    = be_q;
    end

    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (rsp_take && (owner_q == OWN_I)) begin
      if_rvalid_o = 1'b1;
      if_rdata_o  = mem_rdata_i;
    end
    if (rsp_take && (owner_q == OWN_D)) begin
      d_rvalid_o  = 1'b1;
      d_rdata_o   = mem_rdata_i;
    end

    busy_o      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are sampled 3 time units later, mid-cycle.
// Responses expected from memory are queued when the response is driven and
// popped when the DUT routes it to a requester.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk_i;
  logic              rst_ni;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [3:0]        d_be_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [3:0]        mem_be_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;

  int n_pass  = 0;
  int n_total = 0;

  // {owner is data side, response data}
  logic [32:0] sb_q[$];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .d_req_i      (d_req_i),
    .d_we_i       (d_we_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_be_i       (d_be_i),
    .d_gnt_o      (d_gnt_o),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (obs=running exp=finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, ".mem_req"},   64'(mem_req_o),   64'd0);
    chk({tag, ".mem_addr"},  64'(mem_addr_o),  64'd0);
    chk({tag, ".mem_wdata"}, 64'(mem_wdata_o), 64'd0);
    chk({tag, ".mem_be"},    64'(mem_be_o),    64'd0);
    chk({tag, ".mem_we"},    64'(mem_we_o),    64'd0);
  endtask

  // One complete transaction starting in an IDLE cycle with requests already
  // driven. wait_n cycles without mem_gnt_i precede the grant; noise drives
  // mem_rvalid_i during every REQ cycle, including the grant cycle.
  task automatic txn(input string tag, input bit exp_d,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input bit we,
                     input int wait_n, input bit noise, input bit hold,
                     input logic [31:0] rdata);
    logic [32:0] exp_rsp;
    // IDLE: arbitration
    #3;
    chk({tag, ".busy_idle"}, 64'(busy_o),   64'd0);
    chk({tag, ".d_gnt"},     64'(d_gnt_o),  64'(exp_d));
    chk({tag, ".if_gnt"},    64'(if_gnt_o), 64'(!exp_d));
    chk_idle_bus({tag, ".idle"});
    next_cycle();
    if (!hold) begin
      if (exp_d) d_req_i = 1'b0;
      else       if_req_i = 1'b0;
    end
    // REQ: request held stable until mem_gnt_i
    for (int i = 0; i <= wait_n; i++) begin
      mem_gnt_i    = (i == wait_n);
      mem_rvalid_i = noise;
      mem_rdata_i  = 32'hBADBAD00;
      #3;
      chk({tag, ".mem_req"},   64'(mem_req_o),   64'd1);
      chk({tag, ".mem_addr"},  64'(mem_addr_o),  64'(addr));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata_o), 64'(wdata));
      chk({tag, ".mem_be"},    64'(mem_be_o),    64'(be));
      chk({tag, ".mem_we"},    64'(mem_we_o),    64'(we));
      chk({tag, ".gnt_in_req"},    64'({d_gnt_o, if_gnt_o}),       64'd0);
      chk({tag, ".rvalid_in_req"}, 64'({d_rvalid_o, if_rvalid_o}), 64'd0);
      next_cycle();
    end
    // RSP: response routed to owner in the same cycle
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    sb_q.push_back({exp_d, rdata});
    #3;
    chk({tag, ".busy_rsp"}, 64'(busy_o), 64'd1);
    chk_idle_bus({tag, ".rsp"});
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp_rsp = sb_q.pop_front();
      chk({tag, ".d_rvalid"},  64'(d_rvalid_o),  64'(exp_rsp[32]));
      chk({tag, ".if_rvalid"}, 64'(if_rvalid_o), 64'(!exp_rsp[32]));
      chk({tag, ".d_rdata"},   64'(d_rdata_o),   exp_rsp[32] ? 64'(exp_rsp[31:0]) : 64'd0);
      chk({tag, ".if_rdata"},  64'(if_rdata_o),  exp_rsp[32] ? 64'd0 : 64'(exp_rsp[31:0]));
    end
    next_cycle();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  initial begin
    bit guard;
`ifdef MEM_ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    rst_ni       = 1'b0;
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_0AAA;
    d_req_i      = 1'b1;
    d_we_i       = 1'b1;
    d_addr_i     = 32'h0000_0BBB;
    d_wdata_i    = 32'hFFFF_FFFF;
    d_be_i       = 4'hF;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;

    // Reset: nothing granted or driven even with every input active
    #3;
    chk("rst.if_gnt",    64'(if_gnt_o),    64'd0);
    chk("rst.d_gnt",     64'(d_gnt_o),     64'd0);
    chk("rst.rvalid",    64'({if_rvalid_o, d_rvalid_o}), 64'd0);
    chk("rst.rdata",     64'({if_rdata_o, d_rdata_o}),   64'd0);
    chk("rst.busy",      64'(busy_o),      64'd0);
    chk_idle_bus("rst");
    next_cycle();
    next_cycle();
    if_req_i     = 1'b0;
    d_req_i      = 1'b0;
    d_we_i       = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    rst_ni       = 1'b1;
    next_cycle();

    // Fetch only, zero memory latency
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    txn("fetch", 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 0, 1'b0, 1'b0, 32'hDEADBEEF);

    // Both request: store wins, fetch follows in the next IDLE
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = 32'h200;
    d_wdata_i = 32'h12345678;
    d_be_i    = 4'h3;
    if_req_i  = 1'b1;
    if_addr_i = 32'h104;
    txn("both.store", 1'b1, 32'h200, 32'h12345678, 4'h3, 1'b1, 0, 1'b0, 1'b0, 32'h0);
    txn("both.fetch", 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 0, 1'b0, 1'b0, 32'h0BAD_CAFE);

    // Memory stalls the grant for 5 cycles
    d_req_i   = 1'b1;
    d_we_i    = 1'b0;
    d_addr_i  = 32'h240;
    d_wdata_i = 32'h0;
    d_be_i    = 4'hC;
    txn("stall", 1'b1, 32'h240, 32'h0, 4'hC, 1'b0, 5, 1'b0, 1'b0, 32'h5555_AAAA);

    // Stray mem_rvalid_i in IDLE is ignored
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h7777_7777;
    #3;
    chk("idle_rv.rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'd0);
    chk("idle_rv.rdata",  64'({if_rdata_o, d_rdata_o}),   64'd0);
    next_cycle();
    #3;
    chk("idle_rv.busy", 64'(busy_o), 64'd0);
    next_cycle();
    mem_rvalid_i = 1'b0;

    // Stray mem_rvalid_i in REQ, including together with the grant
    if_req_i  = 1'b1;
    if_addr_i = 32'h180;
    txn("req_rv", 1'b0, 32'h180, 32'h0, 4'hF, 1'b0, 2, 1'b1, 1'b0, 32'h1357_9BDF);

    // Reset in RSP, late response after release
    if_req_i  = 1'b1;
    if_addr_i = 32'h500;
    next_cycle();
    if_req_i  = 1'b0;
    mem_gnt_i = 1'b1;
    next_cycle();
    mem_gnt_i = 1'b0;
    #2;
    chk("rst_rsp.busy_before", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_rsp.busy", 64'(busy_o), 64'd0);
    chk("rst_rsp.rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'd0);
    chk_idle_bus("rst_rsp");
    next_cycle();
    rst_ni       = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0BAD;
    #3;
    chk("rst_rsp.late_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'd0);
    chk("rst_rsp.late_rdata",  64'({if_rdata_o, d_rdata_o}),   64'd0);
    chk("rst_rsp.late_busy",   64'(busy_o), 64'd0);
    next_cycle();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;

    // Both requests held for 5 transactions
    d_req_i   = 1'b1;
    d_we_i    = 1'b0;
    d_addr_i  = 32'h300;
    d_wdata_i = 32'h0;
    d_be_i    = 4'hF;
    if_req_i  = 1'b1;
    if_addr_i = 32'h400;
    for (int k = 0; k < 5; k++) begin
      bit exp_d;
      exp_d = !(guard && (k == 3));
      if (exp_d)
        txn($sformatf("held%0d", k), 1'b1, 32'h300, 32'h0, 4'hF, 1'b0, 0, 1'b0, 1'b1, 32'h3000_0000 + k);
      else
        txn($sformatf("held%0d", k), 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, 0, 1'b0, 1'b1, 32'h4000_0000 + k);
    end
    d_req_i  = 1'b0;
    if_req_i = 1'b0;
    next_cycle();

    chk("sb.drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
